// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA reader expanding a 1bpp 64x32 framebuffer (10x15 scaling) to 12-bit RGB
module vga_scanout #(
  parameter logic [31:0] FB_BASE  = 32'h0000_0300,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] va,
  input  logic [31:0] vd,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame
);
  logic [9:0] hc, vc;
  logic [3:0] hsub, vsub;
  logic [5:0] lx;
  logic [4:0] ly;
  logic       h_act, v_act, line_end;
  logic       act1, hs1, vs1, fr1;
  logic [4:0] idx1;
  logic [11:0] rgb;
  assign h_act    = hc < 10'd640;
  assign v_act    = vc < 10'd480;
  assign line_end = hc == 10'd799;
  assign va       = FB_BASE + {24'd0, ly, lx[5], 2'b00};
  assign {vga_r, vga_g, vga_b} = rgb;
  always_ff @(posedge clk) begin
    if (reset) begin
      hc   <= '0;
      vc   <= '0;
      hsub <= '0;
      vsub <= '0;
      lx   <= '0;
      ly   <= '0;
    end else begin
      hc   <= line_end ? '0 : hc + 10'd1;
      hsub <= (h_act && hsub != 4'd9) ? hsub + 4'd1 : '0;
      lx   <= h_act ? lx + {5'd0, hsub == 4'd9} : '0;
      if (line_end) begin
        vc   <= (vc == 10'd524) ? '0 : vc + 10'd1;
        vsub <= (v_act && vsub != 4'd14) ? vsub + 4'd1 : '0;
        ly   <= v_act ? ly + {4'd0, vsub == 4'd14} : '0;
      end
    end
  end
  // Two-stage pipeline: stage 1 meets vd from memory, stage 2 drives the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      act1  <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      fr1   <= 1'b0;
      idx1  <= '0;
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      frame <= 1'b0;
    end else begin
      act1  <= h_act && v_act;
      hs1   <= !(hc >= 10'd656 && hc < 10'd752);
      vs1   <= !(vc >= 10'd490 && vc < 10'd492);
      fr1   <= hc == 10'd0 && vc == 10'd480;
      idx1  <= 5'd31 - lx[4:0];
      rgb   <= act1 ? (vd[idx1] ? FG_COLOR : BG_COLOR) : '0;
      hsync <= hs1;
      vsync <= vs1;
      frame <= fr1;
    end
  end
endmodule
